// File: rtl/dqn_ff_pkg.sv
// Shared definitions for the DQN feed-forward datapath: layer codes, the
// scheduler FSM encoding, and the weight-RAM layout helpers that the
// scheduler, feed_forward and the weight-file generator all agree on.
package dqn_ff_pkg;

  localparam logic [1:0] LAYER_INPUT    = 2'd0;
  localparam logic [1:0] LAYER_HIDDEN_1 = 2'd1;
  localparam logic [1:0] LAYER_HIDDEN_2 = 2'd2;
  localparam logic [1:0] LAYER_OUTPUT   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_e;

  // Weights feeding a layer: one word per (node, source) pair plus one
  // bias word per node. The input layer has no weights.
  function automatic int layer_weight_count(input logic [1:0] layer,
                                            input int n_in, input int n_h1,
                                            input int n_h2, input int n_out);
    int n;
    case (layer)
      LAYER_HIDDEN_1: n = n_h1 * (n_in + 1);
      LAYER_HIDDEN_2: n = n_h2 * (n_h1 + 1);
      LAYER_OUTPUT:   n = n_out * (n_h2 + 1);
      default:        n = 0;
    endcase
    return n;
  endfunction

  // Layer blocks are packed back to back in layer order starting at 0.
  function automatic int layer_base_addr(input logic [1:0] layer,
                                         input int n_in, input int n_h1,
                                         input int n_h2, input int n_out);
    int base;
    base = 0;
    if (layer > LAYER_HIDDEN_1)
      base += layer_weight_count(LAYER_HIDDEN_1, n_in, n_h1, n_h2, n_out);
    if (layer > LAYER_HIDDEN_2)
      base += layer_weight_count(LAYER_HIDDEN_2, n_in, n_h1, n_h2, n_out);
    return base;
  endfunction

endpackage

// File: rtl/weight_stream_scheduler_if.sv
// Bundle between the weight stream scheduler (master side) and its
// environment: feed_forward request/consume signals and the weight RAM
// read port.
//
// Handshake semantics: i_weight_request is a single-cycle pulse sampled on
// the rising edge; there is no ready, rejection is reported by o_error one
// cycle later. o_mem_rd_en/o_mem_addr are registered; the RAM must present
// the addressed word on i_mem_data by the rising edge that closes the read
// cycle. o_weight_valid marks a word the consumer must take that cycle;
// there is no backpressure other than i_pause, which only stops new reads.
interface weight_stream_scheduler_if import dqn_ff_pkg::*; #(
  parameter int DATA_WIDTH  = 32,
  parameter int LAYER_WIDTH = 2,
  parameter int ADDR_WIDTH  = 11
);
  logic [LAYER_WIDTH-1:0] i_current_layer;
  logic                   i_weight_request;
  logic                   i_pause;
  logic                   o_mem_rd_en;
  logic [ADDR_WIDTH-1:0]  o_mem_addr;
  logic [DATA_WIDTH-1:0]  i_mem_data;
  logic                   o_weight_valid;
  logic [DATA_WIDTH-1:0]  o_weight;
  logic                   o_busy;
  logic                   o_layer_done;
  logic                   o_error;
  sched_state_e           dbg_state;
  logic [LAYER_WIDTH-1:0] dbg_layer;

  modport master (
    input  i_current_layer, i_weight_request, i_pause, i_mem_data,
    output o_mem_rd_en, o_mem_addr, o_weight_valid, o_weight,
           o_busy, o_layer_done, o_error, dbg_state, dbg_layer
  );

  modport slave (
    output i_current_layer, i_weight_request, i_pause, i_mem_data,
    input  o_mem_rd_en, o_mem_addr, o_weight_valid, o_weight,
           o_busy, o_layer_done, o_error, dbg_state, dbg_layer
  );
endinterface

// File: rtl/weight_addr_gen.sv
// Burst address generator: loadable read address plus a down-counter of
// reads still to issue. last flags the read that finishes the burst.
module weight_addr_gen #(
  parameter int ADDR_WIDTH = 11,
  parameter int CNT_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [CNT_WIDTH-1:0]  load_count,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;

  // Load wins over step; stepping stops at zero so the address never runs
  // past the end of the block.
  always_comb begin
    addr_d  = addr_q;
    count_d = count_q;
    if (load) begin
      addr_d  = load_addr;
      count_d = load_count;
    end else if (step && (count_q != '0)) begin
      addr_d  = addr_q + ADDR_WIDTH'(1);
      count_d = count_q - CNT_WIDTH'(1);
    end
  end

  // Address and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      count_q <= '0;
    end else begin
      addr_q  <= addr_d;
      count_q <= count_d;
    end
  end

  assign addr = addr_q;
  assign last = (count_q == CNT_WIDTH'(1));

endmodule

// File: rtl/weight_stream_scheduler.sv
// Streams one layer's weight block from the weight RAM to feed_forward on
// request: one read per cycle, returned data registered onto o_weight with
// o_weight_valid following the read strobe by one cycle.
module weight_stream_scheduler import dqn_ff_pkg::*; #(
  parameter int DATA_WIDTH                    = 32,
  parameter int LAYER_WIDTH                   = 2,
  parameter int NUMBER_OF_INPUT_NODE          = 2,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
  parameter int NUMBER_OF_OUTPUT_NODE         = 3,
  parameter int ADDR_WIDTH                    = 11
) (
  input logic                       clk,
  input logic                       rst,
  weight_stream_scheduler_if.master bus
);

  // One extra bit so a full-RAM burst length still fits the counter.
  localparam int CNT_WIDTH = ADDR_WIDTH + 1;

  localparam int N_L1 = layer_weight_count(LAYER_HIDDEN_1, NUMBER_OF_INPUT_NODE,
    NUMBER_OF_HIDDEN_NODE_LAYER_1, NUMBER_OF_HIDDEN_NODE_LAYER_2, NUMBER_OF_OUTPUT_NODE);
  localparam int N_L2 = layer_weight_count(LAYER_HIDDEN_2, NUMBER_OF_INPUT_NODE,
    NUMBER_OF_HIDDEN_NODE_LAYER_1, NUMBER_OF_HIDDEN_NODE_LAYER_2, NUMBER_OF_OUTPUT_NODE);
  localparam int N_L3 = layer_weight_count(LAYER_OUTPUT, NUMBER_OF_INPUT_NODE,
    NUMBER_OF_HIDDEN_NODE_LAYER_1, NUMBER_OF_HIDDEN_NODE_LAYER_2, NUMBER_OF_OUTPUT_NODE);
  localparam int B_L1 = layer_base_addr(LAYER_HIDDEN_1, NUMBER_OF_INPUT_NODE,
    NUMBER_OF_HIDDEN_NODE_LAYER_1, NUMBER_OF_HIDDEN_NODE_LAYER_2, NUMBER_OF_OUTPUT_NODE);
  localparam int B_L2 = layer_base_addr(LAYER_HIDDEN_2, NUMBER_OF_INPUT_NODE,
    NUMBER_OF_HIDDEN_NODE_LAYER_1, NUMBER_OF_HIDDEN_NODE_LAYER_2, NUMBER_OF_OUTPUT_NODE);
  localparam int B_L3 = layer_base_addr(LAYER_OUTPUT, NUMBER_OF_INPUT_NODE,
    NUMBER_OF_HIDDEN_NODE_LAYER_1, NUMBER_OF_HIDDEN_NODE_LAYER_2, NUMBER_OF_OUTPUT_NODE);

  sched_state_e           state_q, state_d;
  logic [LAYER_WIDTH-1:0] layer_q, layer_d;
  logic                   rd_en_q, rd_en_d;
  logic                   weight_valid_q, weight_valid_d;
  logic [DATA_WIDTH-1:0]  weight_q, weight_d;
  logic                   layer_done_q, layer_done_d;
  logic                   error_q, error_d;

  logic                   accept;
  logic                   final_read;
  logic                   addr_last;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [ADDR_WIDTH-1:0]  load_addr;
  logic [CNT_WIDTH-1:0]   load_count;

  // Only an idle scheduler takes a request, and the input layer has no
  // weights, so anything else is rejected.
  assign accept = bus.i_weight_request && (state_q == ST_IDLE) &&
                  (bus.i_current_layer != LAYER_WIDTH'(LAYER_INPUT));
  // The read being issued this cycle is the last word of the block.
  assign final_read = rd_en_q && addr_last;

  // Block base and length for the requested layer, loaded on acceptance.
  always_comb begin
    load_addr  = '0;
    load_count = '0;
    case (bus.i_current_layer)
      LAYER_WIDTH'(LAYER_HIDDEN_1): begin
        load_addr  = ADDR_WIDTH'(B_L1);
        load_count = CNT_WIDTH'(N_L1);
      end
      LAYER_WIDTH'(LAYER_HIDDEN_2): begin
        load_addr  = ADDR_WIDTH'(B_L2);
        load_count = CNT_WIDTH'(N_L2);
      end
      LAYER_WIDTH'(LAYER_OUTPUT): begin
        load_addr  = ADDR_WIDTH'(B_L3);
        load_count = CNT_WIDTH'(N_L3);
      end
      default: ;
    endcase
  end

  weight_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .step       (rd_en_q),
    .load_addr  (load_addr),
    .load_count (load_count),
    .addr       (addr),
    .last       (addr_last)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: FETCH until the final read issues, then one DRAIN
  // cycle while that word returns.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_FETCH;
      ST_FETCH: if (final_read) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: read strobe for the next cycle, latched layer, and the
  // registered return path (data captured only with a returning word).
  always_comb begin
    rd_en_d = 1'b0;
    layer_d = layer_q;
    case (state_q)
      ST_IDLE: begin
        rd_en_d = accept && !bus.i_pause;
        if (accept) layer_d = bus.i_current_layer;
      end
      ST_FETCH: rd_en_d = !bus.i_pause && !final_read;
      default: ;
    endcase
    weight_valid_d = rd_en_q;
    weight_d       = rd_en_q ? bus.i_mem_data : weight_q;
    layer_done_d   = final_read;
    error_d        = bus.i_weight_request && !accept;
  end

  // Output registers; reset drops any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      layer_q        <= '0;
      rd_en_q        <= 1'b0;
      weight_valid_q <= 1'b0;
      weight_q       <= '0;
      layer_done_q   <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      layer_q        <= layer_d;
      rd_en_q        <= rd_en_d;
      weight_valid_q <= weight_valid_d;
      weight_q       <= weight_d;
      layer_done_q   <= layer_done_d;
      error_q        <= error_d;
    end
  end

  assign bus.o_mem_rd_en    = rd_en_q;
  assign bus.o_mem_addr     = addr;
  assign bus.o_weight_valid = weight_valid_q;
  assign bus.o_weight       = weight_q;
  assign bus.o_busy         = (state_q != ST_IDLE);
  assign bus.o_layer_done   = layer_done_q;
  assign bus.o_error        = error_q;
  assign bus.dbg_state      = state_q;
  assign bus.dbg_layer      = layer_q;

endmodule

// File: tb/tb_weight_stream_scheduler.sv
// Bench for weight_stream_scheduler: random RAM image, directed bursts with
// pauses, rejected requests and mid-burst reset, checked against a
// per-layer block model (base + length) feeding expected queues.
module tb_weight_stream_scheduler;
  import dqn_ff_pkg::*;

  localparam int DW = 32;
  localparam int LW = 2;
  localparam int AW = 11;
  localparam int N_IN = 2;
  localparam int H1 = 32;
  localparam int H2 = 32;
  localparam int N_OUT = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  weight_stream_scheduler_if #(.DATA_WIDTH(DW), .LAYER_WIDTH(LW), .ADDR_WIDTH(AW)) bus ();

  weight_stream_scheduler #(
    .DATA_WIDTH                    (DW),
    .LAYER_WIDTH                   (LW),
    .NUMBER_OF_INPUT_NODE          (N_IN),
    .NUMBER_OF_HIDDEN_NODE_LAYER_1 (H1),
    .NUMBER_OF_HIDDEN_NODE_LAYER_2 (H2),
    .NUMBER_OF_OUTPUT_NODE         (N_OUT),
    .ADDR_WIDTH                    (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // RAM model: the addressed word during a read, garbage otherwise.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  assign bus.i_mem_data = bus.o_mem_rd_en ? ram[bus.o_mem_addr] : ~ram[bus.o_mem_addr];

  // ---------------- reference model ----------------
  function automatic int model_len(input int layer);
    case (layer)
      1: return H1 * (N_IN + 1);
      2: return H2 * (H1 + 1);
      3: return N_OUT * (H2 + 1);
      default: return 0;
    endcase
  endfunction

  function automatic int model_base(input int layer);
    int b = 0;
    for (int k = 1; k < layer; k++) b += model_len(k);
    return b;
  endfunction

  // ---------------- scoreboard ----------------
  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_q[$];
  logic          exp_last_q[$];
  int errors = 0;
  int checks = 0;
  int valid_cnt, first_valid_cyc, done_cyc;
  logic [DW-1:0] last_w = '0;
  logic [DW-1:0] mon_w;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_burst(input int layer);
    int n = model_len(layer);
    int b = model_base(layer);
    for (int i = 0; i < n; i++) begin
      exp_addr_q.push_back(AW'(b + i));
      exp_q.push_back(ram[b + i]);
      exp_last_q.push_back(i == n - 1);
    end
  endtask

  task automatic reset_stats();
    valid_cnt = 0;
    first_valid_cyc = -1;
    done_cyc = -1;
  endtask

  // Monitor: every read address and every returned word against the queues.
  always @(negedge clk) begin
    if (rst) begin
      last_w = '0;
    end else begin
      if (bus.o_mem_rd_en) begin
        if (exp_addr_q.size() == 0) check("rd_unexpected", bus.o_mem_rd_en, 0);
        else check("rd_addr", bus.o_mem_addr, exp_addr_q.pop_front());
      end
      if (bus.o_weight_valid) begin
        valid_cnt++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (bus.o_layer_done) done_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("valid_unexpected", bus.o_weight_valid, 0);
        end else begin
          mon_w = exp_q.pop_front();
          check("weight", bus.o_weight, mon_w);
          check("layer_done", bus.o_layer_done, exp_last_q.pop_front());
          last_w = mon_w;
        end
      end else begin
        check("weight_hold", bus.o_weight, last_w);
        check("done_idle", bus.o_layer_done, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start_burst(input int layer, output int t_req);
    reset_stats();
    bus.i_current_layer = LW'(layer);
    bus.i_weight_request = 1'b1;
    push_burst(layer);
    t_req = cyc + 1;
    step();
    bus.i_weight_request = 1'b0;
    bus.i_current_layer = LW'($urandom_range(0, 3));
  endtask

  task automatic wait_not_busy(input int bound, output int fall_cyc);
    int n = 0;
    while (bus.o_busy && n < bound) begin
      step();
      n++;
    end
    fall_cyc = cyc;
    check("busy_timeout", bus.o_busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, bus.o_busy, 0);
    check({tag, "_rd_en"}, bus.o_mem_rd_en, 0);
    check({tag, "_addr"}, bus.o_mem_addr, 0);
    check({tag, "_valid"}, bus.o_weight_valid, 0);
    check({tag, "_weight"}, bus.o_weight, 0);
    check({tag, "_done"}, bus.o_layer_done, 0);
    check({tag, "_error"}, bus.o_error, 0);
    check({tag, "_state"}, bus.dbg_state, ST_IDLE);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t, t2, fall, off, lay, n;
    bus.i_current_layer = '0;
    bus.i_weight_request = 1'b0;
    bus.i_pause = 1'b0;
    for (int i = 0; i < (1 << AW); i++) ram[i] = $urandom;
    reset_stats();

    // Reset state
    repeat (3) step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // Layer 1: exact timing, then a request on the done cycle (rejected)
    // held into the cycle busy falls (accepted).
    start_burst(1, t);
    check("l1_busy_t1", bus.o_busy, 1);
    check("l1_rd_t1", bus.o_mem_rd_en, 1);
    check("l1_layer", bus.dbg_layer, 1);
    repeat (model_len(1)) step();
    check("l1_count", valid_cnt, 96);
    check("l1_first", first_valid_cyc, t + 1);
    check("l1_done", done_cyc, t + 96);
    bus.i_current_layer = LW'(1);
    bus.i_weight_request = 1'b1;
    step();
    check("done_req_err", bus.o_error, 1);
    check("done_req_busy", bus.o_busy, 0);
    reset_stats();
    push_burst(1);
    t2 = cyc + 1;
    step();
    bus.i_weight_request = 1'b0;
    check("fall_req_busy", bus.o_busy, 1);
    check("fall_req_err", bus.o_error, 0);
    wait_not_busy(3000, fall);
    check("l1b_count", valid_cnt, 96);
    check("l1b_first", first_valid_cyc, t2 + 1);
    check("l1b_done", done_cyc, t2 + 96);
    check("l1b_fall", fall, t2 + 97);

    // Layer 2 with a rejected mid-burst request
    start_burst(2, t);
    repeat ($urandom_range(20, 900)) step();
    bus.i_current_layer = LW'($urandom_range(0, 3));
    bus.i_weight_request = 1'b1;
    step();
    bus.i_weight_request = 1'b0;
    check("busy_req_err", bus.o_error, 1);
    check("busy_req_busy", bus.o_busy, 1);
    step();
    check("busy_req_err_pulse", bus.o_error, 0);
    wait_not_busy(3000, fall);
    check("l2_count", valid_cnt, 1056);
    check("l2_done", done_cyc, t + 1056);
    check("l2_fall", fall, t + 1057);

    // Layer-0 request while idle: rejected, nothing starts
    bus.i_current_layer = LW'(0);
    bus.i_weight_request = 1'b1;
    step();
    bus.i_weight_request = 1'b0;
    check("l0_err", bus.o_error, 1);
    check("l0_busy", bus.o_busy, 0);
    check("l0_rd", bus.o_mem_rd_en, 0);
    repeat (2) step();
    check("l0_err_pulse", bus.o_error, 0);
    check("l0_idle", bus.dbg_state, ST_IDLE);

    // Layer 3 with a 5-cycle pause mid-burst
    start_burst(3, t);
    off = $urandom_range(10, 80);
    repeat (off) step();
    bus.i_pause = 1'b1;
    repeat (5) step();
    check("pause_busy", bus.o_busy, 1);
    check("pause_rd", bus.o_mem_rd_en, 0);
    bus.i_pause = 1'b0;
    wait_not_busy(3000, fall);
    check("l3_count", valid_cnt, 99);
    check("l3_span", done_cyc - first_valid_cyc, 98 + 5);
    check("l3_done", done_cyc, t + 99 + 5);

    // Random pause pattern on random layers
    for (int k = 0; k < 3; k++) begin
      lay = $urandom_range(1, 3);
      start_burst(lay, t);
      n = 0;
      while (bus.o_busy && n < 5000) begin
        bus.i_pause = ($urandom_range(0, 3) == 0);
        step();
        n++;
      end
      bus.i_pause = 1'b0;
      wait_not_busy(100, fall);
      check("rand_count", valid_cnt, model_len(lay));
    end

    // Reset at valid #40 of layer 1, then a clean restart
    start_burst(1, t);
    n = 0;
    while (valid_cnt < 40 && n < 200) begin
      step();
      n++;
    end
    check("rst_wait", valid_cnt, 40);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    exp_addr_q.delete();
    exp_q.delete();
    exp_last_q.delete();
    step();
    rst = 1'b0;
    step();
    check("post_rst_idle", bus.o_busy, 0);
    start_burst(1, t);
    check("restart_addr", bus.o_mem_addr, 0);
    wait_not_busy(3000, fall);
    check("restart_count", valid_cnt, 96);
    check("restart_done", done_cyc, t + 96);

    check("exp_q_empty", exp_q.size(), 0);
    check("exp_addr_q_empty", exp_addr_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/weight_stream_scheduler.md
# weight_stream_scheduler

Sequences weight delivery from the unified weight RAM into `feed_forward`. When `feed_forward` raises its weight request for a layer, the scheduler reads that layer's weight block from RAM one word per cycle and streams it on `o_weight`/`o_weight_valid`. Weight order matches `feed_forward`'s consumption order. It replaces the bench-side per-layer weight streamer and is the single owner of the weight RAM read port during inference.

## Interface
- `DATA_WIDTH`, 32: weight word width (IEEE-754 single).
- `LAYER_WIDTH`, 2: layer code width. Codes: 0 = input, 1 = hidden 1, 2 = hidden 2, 3 = output.
- `NUMBER_OF_INPUT_NODE`, 2: input node count.
- `NUMBER_OF_HIDDEN_NODE_LAYER_1`, 32: hidden 1 node count.
- `NUMBER_OF_HIDDEN_NODE_LAYER_2`, 32: hidden 2 node count.
- `NUMBER_OF_OUTPUT_NODE`, 3: output node count.
- `ADDR_WIDTH`, 11: weight RAM address width.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `i_current_layer`, in, LAYER_WIDTH: layer code from `feed_forward` `o_current_layer`.
- `i_weight_request`, in, 1: one-cycle pulse, from `feed_forward` `o_weight_valid`.
- `i_pause`, in, 1: holds issue of new RAM reads while high.
- `o_mem_rd_en`, out, 1: RAM read strobe.
- `o_mem_addr`, out, ADDR_WIDTH: RAM read address.
- `i_mem_data`, in, DATA_WIDTH: RAM read data, valid exactly 1 cycle after `o_mem_rd_en`.
- `o_weight_valid`, out, 1: weight word valid. Drives `feed_forward` `i_weight_valid`.
- `o_weight`, out, DATA_WIDTH: weight word. Drives `feed_forward` `i_weight`.
- `o_busy`, out, 1: high from request acceptance through the last weight.
- `o_layer_done`, out, 1: one-cycle pulse, coincident with the last weight of a burst.
- `o_error`, out, 1: one-cycle pulse when a request is rejected.

## Operation
- Burst length N per layer, with each node's bias word counted:
  - L1 = H1·(IN+1) = 96.
  - L2 = H2·(H1+1) = 1056.
  - L3 = OUT·(H2+1) = 99.
- Base addresses: L1 at 0, L2 at 96, L3 at 1152. Total 1251 words. `ADDR_WIDTH` must cover the total.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE → FETCH: on `i_weight_request` with layer in {1,2,3}. Latch the layer. Load addr = base, count = N.
  - FETCH: each cycle with `i_pause` = 0, assert `o_mem_rd_en` with the current addr, then addr+1 and count−1. On the read where count reaches 0, go to DRAIN.
  - DRAIN: one cycle to return the final in-flight word, then IDLE.
- Output path: `o_weight_valid` is `o_mem_rd_en` delayed 1 cycle. `o_weight` is `i_mem_data`, registered only when valid and otherwise held.
- The latched layer governs the whole burst. Changes on `i_current_layer` mid-burst are ignored.
- Rejected requests (no state change, `o_error` pulsed the next cycle):
  - request while `o_busy` = 1;
  - request with layer 0.
- Address arithmetic is unsigned, width ADDR_WIDTH, and never wraps within a burst.

## Timing
- Reset: all outputs are 0, state is IDLE, counters are 0, and `o_weight` is 0. Reset asserted mid-burst abandons the burst immediately. The in-flight RAM word is discarded.
- Request sampled at edge t:
  - `o_busy` = 1 and first `o_mem_rd_en` (addr = base) at t+1;
  - first `o_weight_valid` at t+2;
  - with no pause, the last weight and `o_layer_done` at t+1+N;
  - `o_busy` falls at t+2+N.
- Pause: when `i_pause` rises, `o_mem_rd_en` drops in that cycle. One already-issued word may still appear the next cycle. Reads resume at the held addr the cycle after `i_pause` falls. `o_busy` stays high throughout.
- Pause during DRAIN has no effect.
- A request in the same cycle as `o_layer_done` is rejected. A request in the cycle `o_busy` falls is accepted.
- No combinational path from inputs to outputs.

## Structure
- Shared package `dqn_ff_pkg` holds:
  - the layer code constants;
  - functions for per-layer weight count and base address, computed from the node-count parameters (also used by `feed_forward` and the weight-file generator).
- One sub-module, `weight_addr_gen`: loadable address register plus down-counter, with `load`/`step`/`last` outputs.
- FSM and output register live in the top level.

## Test plan
- Reset, then request layer 1 at t → 96 consecutive valids at t+2..t+97. Addresses 0..95. Data equals RAM[0..95]. `o_layer_done` at t+97.
- Request layer 2 → 1056 valids. Addresses 96..1151. First word RAM[96], last word RAM[1151].
- Request layer 3 with `i_pause` high for 5 cycles mid-burst → exactly 99 valids, addresses 1152..1250, no duplicates or gaps. Valid stream shows a 5-cycle gap.
- Request during a layer-2 burst, then a request with layer 0 → `o_error` pulses each time. Burst count stays 1056. No new burst from the rejected requests.
- Assert `rst` at valid #40 of layer 1 → all outputs 0 in the same cycle. Next request for layer 1 restarts at addr 0 with 96 words.
- Full inference with `feed_forward` on inputs 0xBFC00000, 0x3FA00000 → three bursts (96/1056/99). Outputs match the golden model.
